// File: rtl/hash_probe_table.sv
// Open-addressed hash table in registers: lookup/insert/delete/clear with
// linear probing (one slot per clock) and tombstone deletion.
module hash_probe_table #(
  parameter int unsigned KEY_W = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [KEY_W-1:0] cmd_key_i,
  output logic             rsp_valid_o,
  output logic [1:0]       rsp_status_o,
  output logic [IDX_W-1:0] rsp_index_o,
  output logic [IDX_W:0]   count_o
);

  localparam int unsigned NCHUNK = (KEY_W + IDX_W - 1) / IDX_W;
  localparam int unsigned PAD_W  = NCHUNK * IDX_W;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_MISS = 2'b01;
  localparam logic [1:0] ST_DUP  = 2'b10;
  localparam logic [1:0] ST_FULL = 2'b11;

  typedef enum logic [1:0] {FSM_IDLE, FSM_PROBE, FSM_RESP} fsm_e;
  typedef enum logic [1:0] {SLOT_EMPTY = 2'b00, SLOT_FULL = 2'b01, SLOT_DEL = 2'b10} slot_e;

  // XOR-fold of the key into IDX_W-bit chunks, top chunk zero-padded
  function automatic logic [IDX_W-1:0] fold_hash(input logic [KEY_W-1:0] key);
    logic [PAD_W-1:0] padded;
    logic [IDX_W-1:0] h;
    padded = PAD_W'(key);
    h      = '0;
    for (int i = 0; i < int'(NCHUNK); i++) h ^= padded[i*IDX_W +: IDX_W];
    return h;
  endfunction

  fsm_e             fsm_q, fsm_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] probe_q, probe_d;
  logic             free_vld_q, free_vld_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [IDX_W-1:0] rsp_index_q, rsp_index_d;
  logic [IDX_W:0]   count_q, count_d;

  logic [KEY_W-1:0] slot_key_q [DEPTH];
  slot_e            slot_st_q  [DEPTH];

  logic             tbl_clr, tbl_we, tbl_kwe;
  logic [IDX_W-1:0] tbl_widx;
  slot_e            tbl_wst;

  logic [IDX_W-1:0] cur_idx, free_sel;
  logic             cur_hit, cur_empty, last_probe, free_any;

  assign cur_idx    = base_q + probe_q;
  assign cur_hit    = (slot_st_q[cur_idx] == SLOT_FULL) && (slot_key_q[cur_idx] == key_q);
  assign cur_empty  = (slot_st_q[cur_idx] == SLOT_EMPTY);
  assign last_probe = (probe_q == IDX_W'(DEPTH - 1));
  // First free slot seen wins; the current slot counts if nothing earlier was free
  assign free_any   = free_vld_q || (slot_st_q[cur_idx] != SLOT_FULL);
  assign free_sel   = free_vld_q ? free_idx_q : cur_idx;

  always_comb begin
    fsm_d        = fsm_q;
    key_d        = key_q;
    op_d         = op_q;
    base_d       = base_q;
    probe_d      = probe_q;
    free_vld_d   = free_vld_q;
    free_idx_d   = free_idx_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_index_d  = rsp_index_q;
    count_d      = count_q;
    tbl_clr      = 1'b0;
    tbl_we       = 1'b0;
    tbl_kwe      = 1'b0;
    tbl_widx     = cur_idx;
    tbl_wst      = SLOT_FULL;

    case (fsm_q)
      FSM_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          if (cmd_op_i == OP_CLEAR) begin
            tbl_clr      = 1'b1;
            count_d      = '0;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_OK;
            rsp_index_d  = '0;
            fsm_d        = FSM_RESP;
          end else begin
            key_d      = cmd_key_i;
            op_d       = cmd_op_i;
            base_d     = fold_hash(cmd_key_i);
            probe_d    = '0;
            free_vld_d = 1'b0;
            free_idx_d = '0;
            fsm_d      = FSM_PROBE;
          end
        end
      end
      FSM_PROBE: begin
        if (cur_hit || cur_empty || last_probe) begin
          fsm_d       = FSM_RESP;
          rsp_valid_d = 1'b1;
          rsp_index_d = '0;
          case (op_q)
            OP_LOOKUP: begin
              rsp_status_d = cur_hit ? ST_OK : ST_MISS;
              if (cur_hit) rsp_index_d = cur_idx;
            end
            OP_INSERT: begin
              if (cur_hit) begin
                rsp_status_d = ST_DUP;
                rsp_index_d  = cur_idx;
              end else if (free_any) begin
                rsp_status_d = ST_OK;
                rsp_index_d  = free_sel;
                tbl_we       = 1'b1;
                tbl_kwe      = 1'b1;
                tbl_widx     = free_sel;
                tbl_wst      = SLOT_FULL;
                count_d      = count_q + (IDX_W+1)'(1);
              end else begin
                rsp_status_d = ST_FULL;
              end
            end
            default: begin
              if (cur_hit) begin
                rsp_status_d = ST_OK;
                rsp_index_d  = cur_idx;
                tbl_we       = 1'b1;
                tbl_wst      = SLOT_DEL;
                count_d      = count_q - (IDX_W+1)'(1);
              end else begin
                rsp_status_d = ST_MISS;
              end
            end
          endcase
        end else begin
          probe_d = probe_q + IDX_W'(1);
          if ((slot_st_q[cur_idx] == SLOT_DEL) && !free_vld_q) begin
            free_vld_d = 1'b1;
            free_idx_d = cur_idx;
          end
        end
      end
      FSM_RESP: fsm_d = FSM_IDLE;
      default:  fsm_d = FSM_IDLE;
    endcase

    ready_d = (fsm_d == FSM_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= FSM_IDLE;
      key_q        <= '0;
      op_q         <= '0;
      base_q       <= '0;
      probe_q      <= '0;
      free_vld_q   <= 1'b0;
      free_idx_q   <= '0;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_index_q  <= '0;
      count_q      <= '0;
    end else begin
      fsm_q        <= fsm_d;
      key_q        <= key_d;
      op_q         <= op_d;
      base_q       <= base_d;
      probe_q      <= probe_d;
      free_vld_q   <= free_vld_d;
      free_idx_q   <= free_idx_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_index_q  <= rsp_index_d;
      count_q      <= count_d;
    end
  end

  // Slot storage: clear empties every slot, otherwise at most one slot written per edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_st_q[i]  <= SLOT_EMPTY;
        slot_key_q[i] <= '0;
      end
    end else if (tbl_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_st_q[i] <= SLOT_EMPTY;
    end else if (tbl_we) begin
      slot_st_q[tbl_widx] <= tbl_wst;
      if (tbl_kwe) slot_key_q[tbl_widx] <= key_q;
    end
  end

  assign cmd_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_index_o  = rsp_index_q;
  assign count_o      = count_q;

endmodule

// File: doc/hash_probe_table.md
# hash_probe_table

Parametrised, stateful successor to the key-match flag array: a register-based open-addressed hash table supporting lookup, insert, delete and clear of KEY_W-bit keys. It probes one slot per clock with linear probing and uses tombstones for deletion. It takes commands over a valid/ready handshake and returns a one-cycle status pulse. It sits between the key/data front-end and the crypto datapath as the membership store for tracked values.

## Interface
- KEY_W, 8: key width in bits (≥ 1).
- DEPTH, 16: slot count; power of two, 2..256.
- IDX_W, $clog2(DEPTH): slot index width (derived; not overridden).
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears table and FSM immediately.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; command accepted on an edge where cmd_valid & cmd_ready.
- cmd_op  in  2  00 lookup, 01 insert, 10 delete, 11 clear.
- cmd_key  in  KEY_W  key operand; ignored for clear.
- rsp_valid  out  1  one-cycle pulse per accepted command; no backpressure.
- rsp_status  out  2  00 OK/HIT, 01 MISS, 10 DUP, 11 FULL.
- rsp_index  out  IDX_W  slot hit, written or deleted; 0 for MISS, FULL and clear.
- count  out  IDX_W+1  number of FULL-state slots; tombstones are not counted.

## Operation
- Each slot holds a key plus a 2-bit state: EMPTY, FULL or DELETED (tombstone). Reset and clear set every slot to EMPTY.
- Hash: XOR-fold of cmd_key into IDX_W-bit chunks, with the top chunk zero-padded. Example for KEY_W=8, DEPTH=16: h = key[7:4]^key[3:0].
- Probe p (starting at 0) examines slot (h+p) mod DEPTH, so indices wrap from DEPTH-1 to 0. At most DEPTH probes are made.
- FSM states: IDLE, PROBE, RESP.
  - IDLE → PROBE on acceptance of lookup, insert or delete. Key and op are latched and p=0.
  - IDLE → RESP on acceptance of clear. The table is emptied on the acceptance edge; status OK.
  - PROBE → RESP on termination; the table write and response registers update on that edge.
  - RESP → IDLE after one cycle.
- Lookup:
  - FULL slot with matching key → HIT, index = slot.
  - EMPTY slot, or DEPTH probes done → MISS.
  - DELETED slots are skipped.
- Insert:
  - The index of the first DELETED or EMPTY slot seen is remembered.
  - A FULL slot with matching key → DUP, index = slot, no write.
  - EMPTY slot, or DEPTH probes done without a match:
    - If a free slot was remembered, write the key there, set it FULL, count+1, status OK, index = that slot.
    - Otherwise → FULL, no write.
- Delete:
  - FULL slot with matching key → set it DELETED, count−1, OK, index = slot.
  - EMPTY slot, or DEPTH probes done → MISS.
- Commands presented while cmd_ready=0 are ignored; the table is not touched.

## Timing
- Reset values: rsp_valid=0, rsp_status=0, rsp_index=0, count=0, state IDLE. cmd_ready=1 once reset deasserts.
- Latency for a probed op terminating after N probes (1 ≤ N ≤ DEPTH):
  - rsp_valid is high in cycle N+1 after the acceptance edge.
  - cmd_ready returns high in cycle N+2.
- Clear: rsp_valid high in cycle 1 after acceptance; cmd_ready high in cycle 2.
- rsp_status and rsp_index are valid only while rsp_valid=1 and hold their values until the next response.
- count updates on the same edge as the table write, so it is visible together with rsp_valid.
- Reset asserted mid-PROBE or mid-RESP:
  - The operation is aborted and the table emptied.
  - No rsp_valid is produced.
  - Outputs go to their reset values asynchronously.
- cmd_valid held high through RESP is accepted at the first IDLE edge only.

## Test plan (KEY_W=8, DEPTH=16)
- Reset, then insert 0x12 (h=3) → OK, index 3, count 1, rsp_valid 2 cycles after acceptance. Then insert 0x21 (h=3) → OK, index 4, N=2, count 2.
- Lookup 0x21 → HIT 4. Delete 0x12 → OK 3, count 1. Lookup 0x21 → HIT 4 (probe passes the tombstone at 3). Lookup 0x55 → MISS, index 0.
- Insert 0x30 (h=3) → OK, index 3 (reuses the tombstone), N=3. Insert 0x21 again → DUP, index 4, count unchanged.
- Wrap-around: insert 0xF0 and 0x0F (both h=15) → indices 15 and 0. Insert 16 distinct keys, then a 17th → FULL after 16 probes, count 16.
- Clear → OK, count 0, 1-cycle latency. Any subsequent lookup → MISS after 1 probe.
- Assert reset during the PROBE of a 5-probe lookup → no rsp_valid, count 0. After release, cmd_ready=1 and the table is empty. cmd_valid pulses while cmd_ready=0 → no effect.
